// File: rtl/except_arbiter_if.sv
// Trap delivery bus from the exception arbiter to the CSR/exception unit.
interface except_arbiter_if;
  logic        exception_valid;
  logic [3:0]  exception;
  logic [31:0] PC;
  logic [31:0] instr;

  modport master (
    output exception_valid,
    output exception,
    output PC,
    output instr
  );

  modport slave (
    input exception_valid,
    input exception,
    input PC,
    input instr
  );
endinterface

// File: rtl/except_arbiter.sv
// Oldest-first exception arbiter: issue one trap, then kill for a drain window.
// Optional EXCEPT_STATS_EN macro adds the trap_count statistics counter.
module except_arbiter #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_ex_valid,
  input  logic [31:0]        if_pc,
  input  logic               id_ex_valid,
  input  logic [3:0]         id_ex_code,
  input  logic [31:0]        id_pc,
  input  logic [31:0]        id_instr,
  input  logic               mem_ex_valid,
  input  logic               mem_is_store,
  input  logic [31:0]        mem_pc,
  input  logic [31:0]        mem_instr,
  except_arbiter_if.master   csr,
  output logic               kill,
  output logic               busy,
  output logic [15:0]        trap_count
);

  localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic        req;
  logic [3:0]  code_sel;
  logic [31:0] pc_sel;
  logic [31:0] instr_sel;

  assign req = if_ex_valid | id_ex_valid | mem_ex_valid;

  // mem is the oldest instruction in flight, fetch the youngest
  always_comb begin
    code_sel  = 4'd0;
    pc_sel    = 32'd0;
    instr_sel = 32'd0;
    priority case (1'b1)
      mem_ex_valid: begin
        code_sel  = mem_is_store ? 4'd6 : 4'd4;
        pc_sel    = mem_pc;
        instr_sel = mem_instr;
      end
      id_ex_valid: begin
        code_sel  = id_ex_code;
        pc_sel    = id_pc;
        instr_sel = id_instr;
      end
      if_ex_valid: begin
        code_sel  = 4'd0;
        pc_sel    = if_pc;
        instr_sel = 32'd0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req) state_nx = ISSUE;
      ISSUE:   state_nx = DRAIN;
      DRAIN:   if (cnt == 4'd1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Status outputs are flopped from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr.exception_valid <= 1'b0;
      kill                <= 1'b0;
      busy                <= 1'b0;
    end else begin
      csr.exception_valid <= (state_nx == ISSUE);
      kill                <= (state_nx != IDLE);
      busy                <= (state_nx != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (state == ISSUE) begin
      cnt <= DRAIN_LD;
    end else if (state == DRAIN) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr.exception <= 4'd0;
      csr.PC        <= 32'd0;
      csr.instr     <= 32'd0;
    end else if (state == IDLE && req) begin
      csr.exception <= code_sel;
      csr.PC        <= pc_sel;
      csr.instr     <= instr_sel;
    end
  end

`ifdef EXCEPT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_count <= 16'd0;
    end else if (state == ISSUE) begin
      trap_count <= trap_count + 16'd1;
    end
  end
`else
  assign trap_count = 16'd0;
`endif

endmodule

// File: doc/except_arbiter.md
# except_arbiter

Collects exception requests from the fetch, decode and memory stages and selects the oldest one by priority. It registers that exception and presents it to the CSR/exception unit as a one-cycle `exception_valid` pulse carrying code, PC and instruction. It then holds the pipeline kill asserted for a fixed drain window so that no younger request can reach the CSR unit. It sits between the pipeline stages and the CSR/exception unit, and is the initiator side of the `exception_valid`/`exception`/`PC`/`instr` interface.

## Interface
- DRAIN_CYCLES, 3: number of DRAIN cycles after the issue cycle; legal range 1..15.
- clk  in  1  pipeline clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_ex_valid  in  1  fetch reports a misaligned target.
- if_pc  in  ADDR_SIZE+1 (32)  the misaligned target address.
- id_ex_valid  in  1  decode reports an exception.
- id_ex_code  in  EX_WIDTH+1 (4)  decode code: 2 illegal, 3 ebreak, 11 ecall.
- id_pc  in  ADDR_SIZE+1  PC of the decode instruction.
- id_instr  in  INSTR_SIZE+1 (32)  the decode instruction word.
- mem_ex_valid  in  1  memory stage reports a misaligned access.
- mem_is_store  in  1  1 = store (code 6), 0 = load (code 4).
- mem_pc  in  ADDR_SIZE+1  PC of the memory instruction.
- mem_instr  in  INSTR_SIZE+1  the memory instruction word.
- exception_valid  out  1  one-cycle pulse to the CSR unit.
- exception  out  EX_WIDTH+1  mcause code.
- PC  out  ADDR_SIZE+1  PC of the trapping instruction.
- instr  out  INSTR_SIZE+1  instruction of the trapping instruction.
- kill  out  1  squash for all stages: high in ISSUE and DRAIN.
- busy  out  1  high whenever state != IDLE.
- trap_count  out  16  number of traps issued (see Configuration).

## Operation
- States: IDLE, ISSUE, DRAIN.
- Reset (asynchronous, while rst_n = 0):
  - state = IDLE.
  - exception_valid, kill and busy = 0.
  - exception, PC, instr = 0.
  - drain counter = 0; trap_count = 0.
- IDLE:
  - The stage request flags are sampled every cycle.
  - Priority, oldest first: mem > id > if.
  - If any flag is high, register the winner's code, PC and instruction, then go to ISSUE.
  - Losing requests are discarded.
- Code mapping:
  - mem: 4 (load) or 6 (store).
  - id: id_ex_code, passed through unchanged.
  - if: EX_INSTR_ADDR_MISALIGN (0), with instr = 0.
- ISSUE (exactly one cycle):
  - exception_valid = 1, kill = 1.
  - Load the drain counter with DRAIN_CYCLES, then go to DRAIN.
- DRAIN:
  - kill = 1, exception_valid = 0.
  - The counter decrements each cycle; when it reaches 1, the next state is IDLE.
- Outside IDLE, all stage requests are ignored and dropped, not queued. The pipeline is being flushed, so those requests are invalid.
- exception, PC and instr hold their last issued values after ISSUE and are only updated on a new capture.
- An unknown id_ex_code is forwarded unchanged; the arbiter does not validate codes.

## Timing
- Latency: a request sampled in cycle N gives exception_valid high in cycle N+1.
- kill is high from N+1 through N+1+DRAIN_CYCLES inclusive.
- busy is high over the same cycles as kill.
- The earliest next accepted request is sampled in cycle N+2+DRAIN_CYCLES.
- A request present in the last DRAIN cycle is ignored. If it is still high one cycle later (IDLE), it is accepted then.
- Simultaneous requests from all three stages: only mem is issued.
- Reset asserted mid-ISSUE or mid-DRAIN: all outputs are 0 immediately, with no clock edge needed. No partial pulse is emitted after rst_n deasserts.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- EXCEPT_STATS_EN defined:
  - trap_count increments by 1 on every ISSUE cycle.
  - It wraps from 0xFFFF to 0x0000 and is reset to 0.
- EXCEPT_STATS_EN undefined:
  - The counter logic is removed and trap_count is tied to 0.
  - All other behaviour is identical.

## Test plan
- Single id illegal: id_ex_valid = 1, code 2, id_pc = 0x100, id_instr = 0xFFFFFFFF for one cycle.
  - Next cycle: exception_valid = 1, exception = 2, PC = 0x100, instr = 0xFFFFFFFF.
  - kill high for 4 cycles (DRAIN_CYCLES = 3).
- Simultaneous requests: if, id (ecall, 11) and mem (store, mem_pc = 0x204) all in one cycle.
  - Response: exception = 6, PC = 0x204, exactly one exception_valid pulse.
- Fetch misaligned: if_pc = 0x302.
  - Response: exception = 0, PC = 0x302, instr = 0.
- Requests during drain: a new mem load request in each DRAIN cycle and in the first IDLE cycle.
  - Only the IDLE-cycle request issues (code 4). Exactly two pulses in total.
- Reset mid-drain: rst_n low during the second DRAIN cycle.
  - kill, busy and exception_valid drop to 0 asynchronously.
  - After release: state IDLE, no pulse.
- With EXCEPT_STATS_EN: 5 separated traps give trap_count = 5. Without the macro, trap_count stays 0.
